regfile_mp: RTL and testbench

- Parametrised multi-port register file with an integrated scoreboard, for the pipelined core.
- Provides NUM_READ combinational read ports and NUM_WRITE write ports.
- Optional write-to-read bypass.
- Per-register busy bits are set when an instruction allocates a destination and cleared on writeback, so issue logic can detect RAW hazards via rd_ready.

---
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard detection.
// Reads are combinational with optional same-cycle write forwarding.
module regfile_mp #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_BITS  = $clog2(REG_COUNT),
  parameter int NUM_READ  = 3,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_READ*REG_BITS-1:0]  rd_addr,
  output logic [NUM_READ*WIDTH-1:0]     rd_data,
  output logic [NUM_READ-1:0]           rd_ready,
  input  logic [NUM_WRITE-1:0]          wr_en,
  input  logic [NUM_WRITE*REG_BITS-1:0] wr_addr,
  input  logic [NUM_WRITE*WIDTH-1:0]    wr_data,
  input  logic                          alloc_en,
  input  logic [REG_BITS-1:0]           alloc_addr,
  input  logic                          flush,
  output logic [REG_COUNT-1:0]          busy_vec
);

  logic [NUM_READ-1:0][REG_BITS-1:0]  w_rd_addr;
  logic [NUM_READ-1:0][WIDTH-1:0]     w_rd_data;
  logic [NUM_WRITE-1:0][REG_BITS-1:0] w_wr_addr;
  logic [NUM_WRITE-1:0][WIDTH-1:0]    w_wr_data;
  logic [NUM_WRITE-1:0]               w_wr_ok;
  logic [REG_COUNT-1:0]               w_busy_nxt;
  logic [REG_COUNT-1:0]               r_busy;
  logic [WIDTH-1:0]                   r_regs [REG_COUNT];

  assign w_rd_addr = rd_addr;
  assign w_wr_addr = wr_addr;
  assign w_wr_data = wr_data;
  assign rd_data   = w_rd_data;
  assign busy_vec  = r_busy;

  // Legal target: in range and not the hardwired zero register.
  function automatic logic legal(input logic [REG_BITS-1:0] a);
    return (32'(a) < 32'(REG_COUNT)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
    assign w_wr_ok[w] = wr_en[w] && legal(w_wr_addr[w]);
  end

  // Later assignments override earlier ones, giving flush > alloc > writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < REG_COUNT; i++) begin
      for (int w = 0; w < NUM_WRITE; w++)
        if (w_wr_ok[w] && (32'(w_wr_addr[w]) == i)) w_busy_nxt[i] = 1'b0;
      if (alloc_en && legal(alloc_addr) && (32'(alloc_addr) == i)) w_busy_nxt[i] = 1'b1;
    end
    if (flush) w_busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++)
        for (int w = 0; w < NUM_WRITE; w++)
          if (w_wr_ok[w] && (32'(w_wr_addr[w]) == i)) r_regs[i] <= w_wr_data[w];
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [WIDTH-1:0] w_data;
    logic             w_rdy;

    // Decode by compare so an out-of-range address never indexes the array.
    always_comb begin
      w_data = '0;
      w_rdy  = 1'b1;
      if (legal(w_rd_addr[r]))
        for (int i = 0; i < REG_COUNT; i++)
          if (32'(w_rd_addr[r]) == i) begin
            w_data = r_regs[i];
            w_rdy  = ~r_busy[i];
          end
      if ((BYPASS != 0) && rstn)
        for (int w = 0; w < NUM_WRITE; w++)
          if (w_wr_ok[w] && (w_wr_addr[w] == w_rd_addr[r])) begin
            w_data = w_wr_data[w];
            w_rdy  = 1'b1;
          end
    end

    assign w_rd_data[r] = w_data;
    assign rd_ready[r]  = w_rdy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a no-bypass build and a 24-register build
// share one set of inputs and are checked against hand-computed values.
module tb_regfile_mp;

  logic              clk = 1'b0;
  logic              rstn;
  logic [2:0][4:0]   rd_a;
  logic [1:0]        wr_en;
  logic [1:0][4:0]   wr_a;
  logic [1:0][31:0]  wr_d;
  logic              alloc_en, flush;
  logic [4:0]        alloc_a;

  logic [2:0][31:0]  d_a, d_b, d_c;
  logic [2:0]        rdy_a, rdy_b, rdy_c;
  logic [31:0]       bv_a, bv_b;
  logic [23:0]       bv_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rstn(rstn), .rd_addr(rd_a), .rd_data(d_a), .rd_ready(rdy_a),
    .wr_en(wr_en), .wr_addr(wr_a), .wr_data(wr_d), .alloc_en(alloc_en),
    .alloc_addr(alloc_a), .flush(flush), .busy_vec(bv_a));

  regfile_mp #(.BYPASS(0)) u_b (
    .clk(clk), .rstn(rstn), .rd_addr(rd_a), .rd_data(d_b), .rd_ready(rdy_b),
    .wr_en(wr_en), .wr_addr(wr_a), .wr_data(wr_d), .alloc_en(alloc_en),
    .alloc_addr(alloc_a), .flush(flush), .busy_vec(bv_b));

  regfile_mp #(.REG_COUNT(24)) u_c (
    .clk(clk), .rstn(rstn), .rd_addr(rd_a), .rd_data(d_c), .rd_ready(rdy_c),
    .wr_en(wr_en), .wr_addr(wr_a), .wr_data(wr_d), .alloc_en(alloc_en),
    .alloc_addr(alloc_a), .flush(flush), .busy_vec(bv_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    alloc_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rd_a = '0; wr_a = '0; wr_d = '0; alloc_a = '0; idle();
    wr_en = 2'b01; wr_a[0] = 5'd5; wr_d[0] = 32'hCAFE_0000;
    alloc_en = 1'b1; alloc_a = 5'd5;
    repeat (2) @(posedge clk);
    #2;
    for (int a = 0; a < 32; a++) begin
      rd_a[0] = 5'(a); rd_a[1] = 5'(a); rd_a[2] = 5'(31 - a);
      #1;
      n_vec++;
      if (d_a !== '0 || rdy_a !== 3'b111 || d_c !== '0 || rdy_c !== 3'b111) begin
        n_err++;
        $display("FAIL reset_read a=%0d: got %h/%b c %h/%b exp 0/111", a, d_a, rdy_a, d_c, rdy_c);
      end
    end
    n_vec++;
    if (bv_a !== '0 || bv_c !== '0) begin
      n_err++; $display("FAIL reset_busy: got %h %h exp 0", bv_a, bv_c);
    end
    idle();
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_write_priority();
    wr_en = 2'b11; wr_a[0] = 5'd5; wr_a[1] = 5'd5;
    wr_d[0] = 32'h1234_5678; wr_d[1] = 32'hDEAD_BEEF;
    tick(); idle(); rd_a[0] = 5'd5; #1;
    n_vec++;
    if (d_a[0] !== 32'hDEAD_BEEF || d_b[0] !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL wr_prio: got %h %h exp deadbeef", d_a[0], d_b[0]);
    end
    wr_en = 2'b01; wr_a[0] = 5'd0; wr_d[0] = 32'hFFFF_FFFF; rd_a[1] = 5'd0; #1;
    n_vec++;
    if (d_a[1] !== '0 || rdy_a[1] !== 1'b1) begin
      n_err++; $display("FAIL x0_bypass: got %h/%b exp 0/1", d_a[1], rdy_a[1]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (d_a[1] !== '0 || d_b[1] !== '0) begin
      n_err++; $display("FAIL x0_write: got %h %h exp 0", d_a[1], d_b[1]);
    end
    wr_en = 2'b11; wr_a[0] = 5'd6; wr_a[1] = 5'd8; wr_d[0] = 32'h66; wr_d[1] = 32'h88;
    tick(); idle(); rd_a[0] = 5'd6; rd_a[1] = 5'd8; rd_a[2] = 5'd5; #1;
    n_vec++;
    if (d_a !== {32'hDEAD_BEEF, 32'h88, 32'h66}) begin
      n_err++; $display("FAIL two_port_wr: got %h exp deadbeef_00000088_00000066", d_a);
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_a[0] = 5'd7; wr_d[0] = 32'h1111;
    tick(); idle();
    wr_en = 2'b01; wr_a[0] = 5'd7; wr_d[0] = 32'hA5A5_0001; rd_a[2] = 5'd7; #1;
    n_vec++;
    if (d_a[2] !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL bypass_on: got %h exp a5a50001", d_a[2]);
    end
    n_vec++;
    if (d_b[2] !== 32'h1111) begin
      n_err++; $display("FAIL bypass_off_now: got %h exp 00001111", d_b[2]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (d_b[2] !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL bypass_off_next: got %h exp a5a50001", d_b[2]);
    end
    wr_en = 2'b11; wr_a[0] = 5'd10; wr_a[1] = 5'd10; wr_d[0] = 32'h10A; wr_d[1] = 32'h10B;
    rd_a[0] = 5'd10; #1;
    n_vec++;
    if (d_a[0] !== 32'h10B) begin
      n_err++; $display("FAIL bypass_prio: got %h exp 0000010b", d_a[0]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (d_b[0] !== 32'h10B) begin
      n_err++; $display("FAIL store_prio: got %h exp 0000010b", d_b[0]);
    end
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_a = 5'd9;
    tick(); idle(); rd_a[1] = 5'd9; #1;
    n_vec++;
    if (bv_a !== 32'h0000_0200 || rdy_a[1] !== 1'b0) begin
      n_err++; $display("FAIL alloc_busy: got %h/%b exp 00000200/0", bv_a, rdy_a[1]);
    end
    tick(); tick();
    wr_en = 2'b10; wr_a[1] = 5'd9; wr_d[1] = 32'd42; #1;
    n_vec++;
    if (rdy_a[1] !== 1'b1 || d_a[1] !== 32'd42) begin
      n_err++; $display("FAIL wb_bypass: got %0d/%b exp 42/1", d_a[1], rdy_a[1]);
    end
    n_vec++;
    if (rdy_b[1] !== 1'b0 || d_b[1] !== '0) begin
      n_err++; $display("FAIL wb_nobypass: got %0d/%b exp 0/0", d_b[1], rdy_b[1]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (bv_a !== '0 || rdy_a[1] !== 1'b1 || d_a[1] !== 32'd42) begin
      n_err++; $display("FAIL wb_clear: got %h %0d/%b exp 0 42/1", bv_a, d_a[1], rdy_a[1]);
    end
  endtask

  task automatic test_alloc_write();
    alloc_en = 1'b1; alloc_a = 5'd3; wr_en = 2'b01; wr_a[0] = 5'd3; wr_d[0] = 32'd7;
    tick(); idle(); rd_a[0] = 5'd3; #1;
    n_vec++;
    if (bv_a !== 32'h8 || d_a[0] !== 32'd7 || rdy_a[0] !== 1'b0) begin
      n_err++; $display("FAIL alloc_wr_same: got %h %0d/%b exp 00000008 7/0", bv_a, d_a[0], rdy_a[0]);
    end
    flush = 1'b1; alloc_en = 1'b1; alloc_a = 5'd4;
    tick(); idle(); #1;
    n_vec++;
    if (bv_a !== '0) begin
      n_err++; $display("FAIL flush_alloc: got %h exp 0", bv_a);
    end
    alloc_en = 1'b1; alloc_a = 5'd0;
    tick(); idle(); #1;
    n_vec++;
    if (bv_a !== '0) begin
      n_err++; $display("FAIL alloc_x0: got %h exp 0", bv_a);
    end
    alloc_en = 1'b1; alloc_a = 5'd30;
    tick(); idle(); #1;
    n_vec++;
    if (bv_a !== 32'h4000_0000 || bv_c !== '0) begin
      n_err++; $display("FAIL alloc_x30: got %h %h exp 40000000 0", bv_a, bv_c);
    end
    flush = 1'b1;
    tick(); idle();
  endtask

  task automatic test_reset_midop();
    wr_en = 2'b11; wr_a[0] = 5'd12; wr_a[1] = 5'd13; wr_d[0] = 32'h55; wr_d[1] = 32'h66;
    tick(); idle();
    alloc_en = 1'b1; alloc_a = 5'd12;
    tick(); idle();
    alloc_en = 1'b1; alloc_a = 5'd13; wr_en = 2'b01; wr_a[0] = 5'd14; wr_d[0] = 32'h77;
    rd_a[0] = 5'd12; rd_a[1] = 5'd13; rd_a[2] = 5'd14;
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (bv_a !== '0 || d_a !== '0 || rdy_a !== 3'b111 || d_b !== '0) begin
      n_err++; $display("FAIL midop_reset: got %h %h/%b %h exp 0 0/111 0", bv_a, d_a, rdy_a, d_b);
    end
    tick(); idle();
    @(negedge clk) rstn = 1'b1;
    #1;
    n_vec++;
    if (bv_a !== '0 || d_a !== '0) begin
      n_err++; $display("FAIL midop_after: got %h %h exp 0 0", bv_a, d_a);
    end
  endtask

  task automatic test_out_of_range();
    wr_en = 2'b01; wr_a[0] = 5'd23; wr_d[0] = 32'hABC;
    tick(); idle();
    rd_a[0] = 5'd30; rd_a[1] = 5'd23;
    wr_en = 2'b01; wr_a[0] = 5'd30; wr_d[0] = 32'hFFFF_FFFF; #1;
    n_vec++;
    if (d_c[0] !== '0 || rdy_c[0] !== 1'b1 || d_c[1] !== 32'hABC) begin
      n_err++; $display("FAIL oor_bypass: got %h/%b %h exp 0/1 00000abc", d_c[0], rdy_c[0], d_c[1]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (d_c[0] !== '0 || rdy_c[0] !== 1'b1 || d_c[1] !== 32'hABC || bv_c !== '0) begin
      n_err++; $display("FAIL oor_write: got %h/%b %h %h exp 0/1 00000abc 0", d_c[0], rdy_c[0], d_c[1], bv_c);
    end
    n_vec++;
    if (d_a[0] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL x30_32reg: got %h exp ffffffff", d_a[0]);
    end
    for (int a = 0; a < 23; a++) begin
      rd_a[2] = 5'(a); #1;
      n_vec++;
      if (d_c[2] !== '0) begin
        n_err++; $display("FAIL oor_alias a=%0d: got %h exp 0", a, d_c[2]);
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, exp finish before 50000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_priority();
    test_bypass();
    test_scoreboard();
    test_alloc_write();
    test_reset_midop();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
